// File: rtl/s526_resp_misr_if.sv
`default_nettype none
// ============================================================================
// s526_resp_misr_if
//   Response/handshake bundle between the s526n response compactor and the
//   harness that drives the core outputs and collects the signature.
//   Rev 1.0 - initial release
// ============================================================================
interface s526_resp_misr_if;
    logic [5:0]  resp_in;
    logic        start;
    logic        clr;
    logic        sig_ack;
    logic        busy;
    logic        sig_valid;
    logic [15:0] sig_out;
    logic [15:0] chg_cnt;

    modport master (
        output resp_in, start, clr, sig_ack,
        input  busy, sig_valid, sig_out, chg_cnt
    );

    modport slave (
        input  resp_in, start, clr, sig_ack,
        output busy, sig_valid, sig_out, chg_cnt
    );
endinterface
`default_nettype wire

// File: rtl/s526_resp_misr.sv
`default_nettype none
// ============================================================================
// s526_resp_misr
//   16-bit MISR and transition counter over a WINDOW-sample run of the s526n
//   core outputs, presented through a valid/ack handshake.
//   Rev 1.0 - initial release
// ============================================================================
module s526_resp_misr #(
    parameter int          SIG_W  = 16,
    parameter logic [15:0] POLY   = 16'h100B,
    parameter logic [15:0] SEED   = 16'h0000,
    parameter int          WINDOW = 256
) (
    input  wire logic        blif_clk_net,
    input  wire logic        blif_reset_net,
    s526_resp_misr_if.slave  bus
);

    localparam int                CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SIG_W-1:0]   r_sig;
    logic [SIG_W-1:0]   w_sig_nxt;
    logic [15:0]        r_chg;
    logic [15:0]        w_chg_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [5:0]         r_prev;
    logic [5:0]         w_prev_nxt;
    logic [SIG_W-1:0]   w_sig_step;

    // One MISR step: shift, fold the feedback mask, inject the six outputs
    assign w_sig_step = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                      ^ {{(SIG_W-6){1'b0}}, bus.resp_in};

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_chg_nxt   = r_chg;
        w_cnt_nxt   = r_cnt;
        w_prev_nxt  = r_prev;
        if (bus.clr) begin
            w_state_nxt = IDLE;
            w_sig_nxt   = '0;
            w_chg_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = RUN;
                        w_sig_nxt   = SEED;
                        w_chg_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_prev_nxt  = '0;
                    end
                end
                RUN: begin
                    w_sig_nxt  = w_sig_step;
                    w_prev_nxt = bus.resp_in;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if ((bus.resp_in != r_prev) && (r_chg != 16'hFFFF)) begin
                        w_chg_nxt = r_chg + 16'd1;
                    end
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    // start is deliberately ignored here, even alongside ack
                    if (bus.sig_ack) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_sig  <= '0;
            r_chg  <= '0;
            r_cnt  <= '0;
            r_prev <= '0;
        end else begin
            r_sig  <= w_sig_nxt;
            r_chg  <= w_chg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_prev <= w_prev_nxt;
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.sig_valid = (r_state == HOLD);
    assign bus.sig_out   = r_sig;
    assign bus.chg_cnt   = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_s526_resp_misr.sv
`default_nettype none
// ============================================================================
// tb_s526_resp_misr
//   Directed self-checking bench for s526_resp_misr.
//   Rev 1.0 - initial release
// ============================================================================
module tb_s526_resp_misr;

    logic blif_clk_net;
    logic blif_reset_net;
    int   total;
    int   bad;

    s526_resp_misr_if ifa ();
    s526_resp_misr_if ifb ();
    s526_resp_misr_if ifc ();
    s526_resp_misr_if ifd ();

    s526_resp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h0000), .WINDOW(4)) dut_a (
        .blif_clk_net(blif_clk_net), .blif_reset_net(blif_reset_net), .bus(ifa));
    s526_resp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h8000), .WINDOW(1)) dut_b (
        .blif_clk_net(blif_clk_net), .blif_reset_net(blif_reset_net), .bus(ifb));
    s526_resp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h0000), .WINDOW(65535)) dut_c (
        .blif_clk_net(blif_clk_net), .blif_reset_net(blif_reset_net), .bus(ifc));
    // Window longer than the count range, so the transition counter must saturate
    s526_resp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h0000), .WINDOW(65540)) dut_d (
        .blif_clk_net(blif_clk_net), .blif_reset_net(blif_reset_net), .bus(ifd));

    initial blif_clk_net = 1'b0;
    always #5 blif_clk_net = ~blif_clk_net;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge blif_clk_net);
    endtask

    // Run on dut_a: 6'h01 on the first sample, 6'h00 afterwards
    task automatic run_a_onehot(input string tag);
        ifa.start = 1'b1;
        ifa.resp_in = 6'h00;
        tick();
        chk({tag, "_busy"}, 32'(ifa.busy), 32'd1);
        ifa.start = 1'b0;
        ifa.resp_in = 6'h01;
        tick();
        chk({tag, "_s1"}, 32'(ifa.sig_out), 32'h0001);
        ifa.resp_in = 6'h00;
        tick();
        chk({tag, "_s2"}, 32'(ifa.sig_out), 32'h0002);
        tick();
        chk({tag, "_s3"}, 32'(ifa.sig_out), 32'h0004);
        chk({tag, "_v3"}, 32'(ifa.sig_valid), 32'd0);
        tick();
        chk({tag, "_sig"}, 32'(ifa.sig_out), 32'h0008);
        chk({tag, "_chg"}, 32'(ifa.chg_cnt), 32'd2);
        chk({tag, "_valid"}, 32'(ifa.sig_valid), 32'd1);
    endtask

    task automatic ack_a();
        ifa.sig_ack = 1'b1;
        tick();
        ifa.sig_ack = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        blif_reset_net = 1'b1;
        ifa.resp_in = '0; ifa.start = 0; ifa.clr = 0; ifa.sig_ack = 0;
        ifb.resp_in = '0; ifb.start = 0; ifb.clr = 0; ifb.sig_ack = 0;
        ifc.resp_in = '0; ifc.start = 0; ifc.clr = 0; ifc.sig_ack = 0;
        ifd.resp_in = '0; ifd.start = 0; ifd.clr = 0; ifd.sig_ack = 0;
        repeat (2) tick();
        blif_reset_net = 1'b0;
        tick();
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_valid", 32'(ifa.sig_valid), 32'd0);
        chk("rst_sig", 32'(ifa.sig_out), 32'd0);
        chk("rst_chg", 32'(ifa.chg_cnt), 32'd0);

        // Constant zero response, window of 4
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("z_busy", 32'(ifa.busy), 32'd1);
        chk("z_v0", 32'(ifa.sig_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("z_vrun", 32'(ifa.sig_valid), 32'd0);
        end
        tick();
        chk("z_valid", 32'(ifa.sig_valid), 32'd1);
        chk("z_sig", 32'(ifa.sig_out), 32'h0000);
        chk("z_chg", 32'(ifa.chg_cnt), 32'd0);
        ack_a();
        chk("z_ackv", 32'(ifa.sig_valid), 32'd0);
        chk("z_ackb", 32'(ifa.busy), 32'd0);

        run_a_onehot("oh");

        // HOLD ignores resp_in and start until acknowledged
        for (int i = 0; i < 10; i++) begin
            ifa.resp_in = 6'(i) ^ 6'h2A;
            ifa.start = (i % 2) == 0;
            tick();
            chk("hold_sig", 32'(ifa.sig_out), 32'h0008);
            chk("hold_chg", 32'(ifa.chg_cnt), 32'd2);
            chk("hold_valid", 32'(ifa.sig_valid), 32'd1);
        end
        ifa.start = 1'b1;
        ifa.sig_ack = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.sig_ack = 1'b0;
        chk("ackst_valid", 32'(ifa.sig_valid), 32'd0);
        chk("ackst_busy", 32'(ifa.busy), 32'd0);
        chk("idle_sig", 32'(ifa.sig_out), 32'h0008);
        chk("idle_chg", 32'(ifa.chg_cnt), 32'd2);
        tick();
        chk("ackst_busy2", 32'(ifa.busy), 32'd0);

        // Single-sample window with a seed that triggers feedback
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        tick();
        chk("w1_valid", 32'(ifb.sig_valid), 32'd1);
        chk("w1_sig", 32'(ifb.sig_out), 32'h100B);
        chk("w1_chg", 32'(ifb.chg_cnt), 32'd0);
        repeat (3) tick();
        chk("w1_held", 32'(ifb.sig_valid), 32'd1);
        ifb.sig_ack = 1'b1;
        tick();
        ifb.sig_ack = 1'b0;
        chk("w1_drop", 32'(ifb.sig_valid), 32'd0);

        // Abort after two samples, then an uninterrupted rerun
        ifa.start = 1'b1;
        ifa.resp_in = 6'h00;
        tick();
        ifa.start = 1'b0;
        ifa.resp_in = 6'h01;
        tick();
        ifa.resp_in = 6'h00;
        tick();
        chk("clr_pre", 32'(ifa.sig_out), 32'h0002);
        ifa.clr = 1'b1;
        tick();
        ifa.clr = 1'b0;
        chk("clr_busy", 32'(ifa.busy), 32'd0);
        chk("clr_valid", 32'(ifa.sig_valid), 32'd0);
        chk("clr_sig", 32'(ifa.sig_out), 32'd0);
        chk("clr_chg", 32'(ifa.chg_cnt), 32'd0);
        run_a_onehot("rerun");
        ack_a();

        // Asynchronous reset between edges mid-run
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.resp_in = 6'h01;
        tick();
        ifa.resp_in = 6'h00;
        tick();
        chk("ar_pre", 32'(ifa.sig_out), 32'h0002);
        #2 blif_reset_net = 1'b1;
        #1;
        chk("ar_busy", 32'(ifa.busy), 32'd0);
        chk("ar_valid", 32'(ifa.sig_valid), 32'd0);
        chk("ar_sig", 32'(ifa.sig_out), 32'd0);
        chk("ar_chg", 32'(ifa.chg_cnt), 32'd1 - 32'd1);
        tick();
        blif_reset_net = 1'b0;
        tick();
        chk("ar_idle", 32'(ifa.busy), 32'd0);

        // Alternating full-swing response: every sample is a transition
        ifc.start = 1'b1;
        ifd.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifd.start = 1'b0;
        ifc.resp_in = 6'h3F;
        ifd.resp_in = 6'h3F;
        for (int i = 0; i < 65545; i++) begin
            tick();
            ifc.resp_in = ~ifc.resp_in;
            ifd.resp_in = ~ifd.resp_in;
        end
        chk("big_valid", 32'(ifc.sig_valid), 32'd1);
        chk("big_chg", 32'(ifc.chg_cnt), 32'h0000FFFF);
        chk("sat_valid", 32'(ifd.sig_valid), 32'd1);
        chk("sat_chg", 32'(ifd.chg_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
